// File: rtl/tpu_job_sequencer.sv
// tpu_job_sequencer: runs one TPU job per start pulse.
// Loads A/B words, launches the TPU, waits for it, drains C rows as words.
module tpu_job_sequencer #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 32,
  parameter int C_BITS    = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   load_len,
  input  logic [ADDR_BITS:0]   drain_len,
  input  logic [8:0]           input_offset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_a,
  input  logic [DATA_BITS-1:0] in_b,
  output logic                 buf_wr_en,
  output logic [ADDR_BITS-1:0] buf_index,
  output logic [DATA_BITS-1:0] buf_a_data,
  output logic [DATA_BITS-1:0] buf_b_data,
  output logic                 tpu_in_valid,
  output logic [8:0]           tpu_input_offset,
  input  logic                 tpu_busy,
  output logic [ADDR_BITS-1:0] c_index,
  input  logic [C_BITS-1:0]    c_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = ADDR_BITS + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_WAIT_HI,
    S_WAIT_LO,
    S_RD,
    S_CAP,
    S_OUT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]     r_load_len;
  logic [CW-1:0]     r_drain_len;
  logic [CW-1:0]     r_wcnt;
  logic [CW-1:0]     r_rcnt;
  logic [8:0]        r_offset;
  logic [C_BITS-1:0] r_row;
  logic [1:0]        r_sel;

  logic w_wr;
  logic w_acc;
  logic w_wlast;
  logic w_rlast;

  assign w_wr    = (r_state == S_LOAD) && in_valid;
  assign w_acc   = (r_state == S_OUT) && out_ready;
  assign w_wlast = r_wcnt == r_load_len - CW'(1);
  assign w_rlast = r_rcnt == r_drain_len - CW'(1);

  assign in_ready         = r_state == S_LOAD;
  assign buf_wr_en        = w_wr;
  assign buf_index        = w_wr ? r_wcnt[ADDR_BITS-1:0] : '0;
  assign buf_a_data       = w_wr ? in_a : '0;
  assign buf_b_data       = w_wr ? in_b : '0;
  assign tpu_in_valid     = r_state == S_LAUNCH;
  assign tpu_input_offset = r_offset;
  assign c_index          = r_rcnt[ADDR_BITS-1:0];
  assign out_valid        = r_state == S_OUT;
  assign out_last         = (r_state == S_OUT) && (r_sel == 2'd3) && w_rlast;
  assign busy             = r_state != S_IDLE;
  assign done             = r_state == S_DONE;

  // Most significant word of the row goes out first.
  always_comb begin
    out_data = '0;
    unique case (r_sel)
      2'd0: out_data = r_row[4*DATA_BITS-1 -: DATA_BITS];
      2'd1: out_data = r_row[3*DATA_BITS-1 -: DATA_BITS];
      2'd2: out_data = r_row[2*DATA_BITS-1 -: DATA_BITS];
      2'd3: out_data = r_row[DATA_BITS-1 -: DATA_BITS];
      default: out_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = (load_len == '0) ? S_LAUNCH : S_LOAD;
      end
      S_LOAD: begin
        if (w_wr && w_wlast) w_next = S_LAUNCH;
      end
      S_LAUNCH:  w_next = S_WAIT_HI;
      S_WAIT_HI: begin
        if (tpu_busy) w_next = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tpu_busy)
          w_next = (r_drain_len != '0) ? S_RD : S_DONE;
      end
      S_RD:  w_next = S_CAP;
      S_CAP: w_next = S_OUT;
      S_OUT: begin
        if (w_acc && r_sel == 2'd3)
          w_next = w_rlast ? S_DONE : S_RD;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_len  <= '0;
      r_drain_len <= '0;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_offset    <= '0;
      r_row       <= '0;
      r_sel       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_load_len  <= load_len;
            r_drain_len <= drain_len;
            r_offset    <= input_offset;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
          end
        end
        S_LOAD: begin
          if (w_wr) r_wcnt <= r_wcnt + CW'(1);
        end
        S_CAP: begin
          r_row <= c_data;
          r_sel <= '0;
        end
        S_OUT: begin
          if (w_acc) begin
            r_sel <= r_sel + 2'd1;
            if (r_sel == 2'd3) r_rcnt <= r_rcnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Randomized bench for tpu_job_sequencer with a job-level reference model.
// One process drives stimulus, models the TPU and C buffer, and checks.
module tb_tpu_job_sequencer;
  logic         clk;
  logic         reset;
  logic         start;
  logic [6:0]   load_len;
  logic [6:0]   drain_len;
  logic [8:0]   input_offset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_a;
  logic [31:0]  in_b;
  logic         buf_wr_en;
  logic [5:0]   buf_index;
  logic [31:0]  buf_a_data;
  logic [31:0]  buf_b_data;
  logic         tpu_in_valid;
  logic [8:0]   tpu_input_offset;
  logic         tpu_busy;
  logic [5:0]   c_index;
  logic [127:0] c_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  tpu_job_sequencer #(
    .ADDR_BITS(6),
    .DATA_BITS(32),
    .C_BITS(128)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .load_len(load_len),
    .drain_len(drain_len),
    .input_offset(input_offset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .buf_wr_en(buf_wr_en),
    .buf_index(buf_index),
    .buf_a_data(buf_a_data),
    .buf_b_data(buf_b_data),
    .tpu_in_valid(tpu_in_valid),
    .tpu_input_offset(tpu_input_offset),
    .tpu_busy(tpu_busy),
    .c_index(c_index),
    .c_data(c_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_pass;

  logic [31:0]  src_a [64];
  logic [31:0]  src_b [64];
  logic [127:0] cmem  [64];

  int          wr_idx_q [$];
  logic [31:0] wr_a_q   [$];
  logic [31:0] wr_b_q   [$];
  logic [31:0] out_q    [$];
  bit          last_q   [$];

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      src_a[i] = $urandom;
      src_b[i] = $urandom;
      cmem[i]  = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic run_job(input int L, input int D, input int off,
                         input int in_mode, input int out_mode,
                         input int stall_at, input int hi_len,
                         input bit spam, input int abort_at,
                         input string tag);
    int src_i, cyc, n_launch, n_done, busy_cnt, stall_left, c_idx;
    int wb, k, r, s;
    bit got_done, launch_pend, tog, held_v, held_l, aborted, bad;
    logic [31:0]  held_d, ew;
    logic [8:0]   launch_off;
    logic [127:0] row;
    wr_idx_q.delete();
    wr_a_q.delete();
    wr_b_q.delete();
    out_q.delete();
    last_q.delete();
    src_i = 0; cyc = 0; n_launch = 0; n_done = 0; busy_cnt = 0;
    stall_left = 3; c_idx = 0; got_done = 0; launch_pend = 0;
    tog = 0; held_v = 0; held_l = 0; aborted = 0;
    held_d = '0; launch_off = '0;
    @(posedge clk); #1;
    start = 1'b1;
    load_len = 7'(L);
    drain_len = 7'(D);
    input_offset = 9'(off);
    while (!got_done && !aborted && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (held_v) begin
        n_total++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l)
          $display("FAIL %s stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   tag, out_valid, out_data, out_last, held_d, held_l);
        else n_pass++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      if (buf_wr_en) begin
        wr_idx_q.push_back(int'(buf_index));
        wr_a_q.push_back(buf_a_data);
        wr_b_q.push_back(buf_b_data);
      end
      if (in_valid && in_ready) src_i++;
      if (tpu_in_valid) begin
        n_launch++;
        launch_off = tpu_input_offset;
        launch_pend = 1;
      end
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      if (done) begin
        n_done++;
        got_done = 1;
      end
      c_idx = int'(c_index);
      @(posedge clk); #1;
      c_data = cmem[c_idx];
      if (launch_pend) begin
        busy_cnt = hi_len;
        launch_pend = 0;
      end
      tpu_busy = busy_cnt > 0;
      if (busy_cnt > 0) busy_cnt--;
      tog = !tog;
      in_valid = (src_i < L) && (in_mode == 0 || (in_mode == 1 && tog) ||
                 (in_mode == 2 && $urandom_range(1, 0) == 1));
      if (src_i < L) begin
        in_a = src_a[src_i];
        in_b = src_b[src_i];
      end
      if (stall_at >= 0 && out_q.size() == stall_at && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = (out_mode == 0) || ($urandom_range(3, 0) != 0);
      end
      start = spam && !got_done;
      if (spam) begin
        load_len = 7'($urandom_range(64, 0));
        drain_len = 7'($urandom_range(64, 0));
        input_offset = 9'($urandom);
      end
      if (abort_at >= 0 && out_q.size() >= abort_at) begin
        reset = 1'b1;
        aborted = 1;
      end
    end

    if (aborted) begin
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      in_valid = 1'b0;
      tpu_busy = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL %s abort_idle: got busy=%b ov=%b done=%b rdy=%b want 0 0 0 0",
                 tag, busy, out_valid, done, in_ready);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (buf_wr_en !== 1'b0 || tpu_in_valid !== 1'b0 || busy !== 1'b0) bad = 1;
      end
      n_total++;
      if (bad) $display("FAIL %s abort_quiet: got activity after reset want none", tag);
      else n_pass++;
      return;
    end

    n_total++;
    if (!got_done) $display("FAIL %s timeout: got no done want done within 3000 cycles", tag);
    else n_pass++;

    n_total++;
    if (wr_idx_q.size() != L) begin
      $display("FAIL %s wr_count: got %0d want %0d", tag, wr_idx_q.size(), L);
    end else begin
      n_pass++;
      wb = 0;
      for (int i = 0; i < L; i++)
        if (wr_idx_q[i] != i || wr_a_q[i] !== src_a[i] || wr_b_q[i] !== src_b[i]) begin
          if (wb == 0)
            $display("FAIL %s wr_data[%0d]: got idx=%0d a=%h b=%h want idx=%0d a=%h b=%h",
                     tag, i, wr_idx_q[i], wr_a_q[i], wr_b_q[i], i, src_a[i], src_b[i]);
          wb++;
        end
      n_total++;
      if (wb == 0) n_pass++;
    end

    n_total++;
    if (n_launch != 1 || launch_off !== 9'(off))
      $display("FAIL %s launch: got n=%0d off=%0d want n=1 off=%0d",
               tag, n_launch, launch_off, off);
    else n_pass++;

    n_total++;
    if (out_q.size() != 4 * D) begin
      $display("FAIL %s out_count: got %0d want %0d", tag, out_q.size(), 4 * D);
    end else begin
      n_pass++;
      wb = 0;
      for (k = 0; k < 4 * D; k++) begin
        r = k / 4;
        s = k % 4;
        row = cmem[r];
        ew = 32'(row >> (32 * (3 - s)));
        if (out_q[k] !== ew || last_q[k] != (k == 4 * D - 1)) begin
          if (wb == 0)
            $display("FAIL %s out_word[%0d]: got d=%h last=%b want d=%h last=%b",
                     tag, k, out_q[k], last_q[k], ew, (k == 4 * D - 1));
          wb++;
        end
      end
      n_total++;
      if (wb == 0) n_pass++;
    end

    n_total++;
    if (n_done != 1) $display("FAIL %s done_count: got %0d want 1", tag, n_done);
    else n_pass++;

    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    tpu_busy = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s post_done_idle: got busy=%b done=%b want 0 0", tag, busy, done);
    else n_pass++;
  endtask

  task automatic test_reset();
    bit bad;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || tpu_in_valid !== 1'b0 || done !== 1'b0) bad = 1;
    end
    n_total++;
    if (bad) $display("FAIL reset_idle_5: got activity want busy/launch/done low");
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || buf_wr_en !== 1'b0)
      $display("FAIL reset_hs: got rdy=%b ov=%b wr=%b want 0 0 0",
               in_ready, out_valid, buf_wr_en);
    else n_pass++;
    n_total++;
    if (out_last !== 1'b0 || tpu_input_offset !== 9'd0 || c_index !== 6'd0 ||
        out_data !== 32'd0 || buf_index !== 6'd0)
      $display("FAIL reset_regs: got last=%b off=%0d ci=%0d od=%h bi=%0d want zeros",
               out_last, tpu_input_offset, c_index, out_data, buf_index);
    else n_pass++;
  endtask

  task automatic set_basic_data();
    fill_random();
    for (int i = 0; i < 4; i++) begin
      src_a[i] = 32'h11 + 32'(i);
      src_b[i] = 32'h21 + 32'(i);
    end
    cmem[0] = 128'hAAAABBBBCCCCDDDDEEEEFFFF00001111;
  endtask

  task automatic test_basic();
    set_basic_data();
    run_job(4, 1, 128, 0, 0, -1, 10, 0, -1, "basic");
  endtask

  task automatic test_stall();
    set_basic_data();
    run_job(4, 1, 128, 1, 0, 1, 10, 0, -1, "stall");
  endtask

  task automatic test_zero_load();
    fill_random();
    run_job(0, 2, 77, 0, 0, -1, 6, 0, -1, "zero_load");
  endtask

  task automatic test_start_ignored();
    fill_random();
    run_job(5, 3, 300, 0, 0, -1, 12, 1, -1, "start_ignored");
  endtask

  task automatic test_reset_mid_job();
    fill_random();
    run_job(3, 3, 45, 0, 0, -1, 5, 0, 5, "abort");
    fill_random();
    run_job(6, 3, 46, 2, 1, -1, 7, 0, -1, "after_abort");
  endtask

  task automatic test_random();
    for (int j = 0; j < 5; j++) begin
      fill_random();
      run_job(int'($urandom_range(64, 0)), int'($urandom_range(64, 0)),
              int'($urandom_range(511, 0)), 2, 1, -1,
              int'($urandom_range(12, 1)), 0, -1, "random");
    end
    fill_random();
    run_job(64, 64, 511, 2, 1, -1, 3, 0, -1, "full_depth");
    fill_random();
    run_job(1, 0, 0, 0, 0, -1, 1, 0, -1, "no_drain");
  endtask

  initial begin
    n_total = 0;
    n_pass = 0;
    reset = 1'b1;
    start = 1'b0;
    load_len = '0;
    drain_len = '0;
    input_offset = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    tpu_busy = 1'b0;
    c_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_zero_load();
    test_start_ignored();
    test_reset_mid_job();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tpu_job_sequencer.md
Name: tpu_job_sequencer

Overview:
- Autonomous controller that runs one complete TPU job per start pulse, so the CPU does not have to issue per-word commands.
- Streams A/B operand words into the global buffers, pulses the TPU launch, and waits for the TPU to finish.
- Then reads C rows back and streams each 128-bit row out as four 32-bit words over a valid/ready interface.
- Sits inside the CFU between the command decoder and the gbuff_A/B/C ports. The CFU muxes the buffer ports to this block whenever the TPU is idle.

Parameters:
- ADDR_BITS, 6, buffer index width; max depth is 2^ADDR_BITS.
- DATA_BITS, 32, width of A/B buffer words and output words.
- C_BITS, 128, width of a C buffer row; must equal 4*DATA_BITS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  1-cycle job request
- load_len  in  ADDR_BITS+1  number of A/B word pairs to load (0..64)
- drain_len  in  ADDR_BITS+1  number of C rows to drain (0..64)
- input_offset  in  9  offset passed to the TPU
- in_valid  in  1  operand stream valid
- in_ready  out  1  operand stream ready
- in_a  in  DATA_BITS  A word
- in_b  in  DATA_BITS  B word
- buf_wr_en  out  1  A/B buffer write enable
- buf_index  out  ADDR_BITS  A/B buffer write address
- buf_a_data  out  DATA_BITS  A write data
- buf_b_data  out  DATA_BITS  B write data
- tpu_in_valid  out  1  TPU launch pulse
- tpu_input_offset  out  9  registered offset to the TPU
- tpu_busy  in  1  TPU busy
- c_index  out  ADDR_BITS  C buffer read address
- c_data  in  C_BITS  C read data, valid 1 cycle after c_index
- out_valid  out  1  result stream valid
- out_ready  in  1  result stream ready
- out_data  out  DATA_BITS  result word
- out_last  out  1  asserted on the final result word of the job
- busy  out  1  job in progress
- done  out  1  1-cycle pulse at job end

Behaviour:
- Reset (synchronous, active-high) forces state IDLE. All outputs are 0 after reset, including counters, tpu_in_valid, buf_wr_en, out_valid and done.
- Reset mid-job aborts immediately. No further buffer writes occur and no TPU pulse is issued after reset.
- busy = (state != IDLE). start is ignored while busy.
- In IDLE, start=1 samples load_len, drain_len and input_offset into registers, then moves to LOAD. If the sampled load_len=0, go directly to LAUNCH.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&in_ready: buf_wr_en=1, buf_index=wcnt, data = in_a/in_b. Writes are combinational in the same cycle; no registering.
  - wcnt increments after each write.
  - After the write with wcnt==load_len-1, go to LAUNCH.
  - in_ready=0 in every other state.
- LAUNCH: tpu_in_valid=1 for exactly one cycle; tpu_input_offset holds the sampled value. Then WAIT_HI.
- WAIT_HI: wait for tpu_busy=1, then WAIT_LO. If tpu_busy is already 1 in the LAUNCH cycle, still pass through WAIT_HI, which exits the next cycle when tpu_busy=1.
- WAIT_LO: wait for tpu_busy=0. Then go to RD if drain_len!=0, otherwise DONE.
- RD: drive c_index=rcnt for one cycle, then CAP.
- CAP: latch c_data into row_reg, set sel=0, go to OUT.
- OUT:
  - out_valid=1.
  - out_data order: sel 0 = row_reg[127:96], 1 = [95:64], 2 = [63:32], 3 = [31:0].
  - On out_valid&out_ready, sel increments.
  - When sel==3 is accepted, rcnt increments, then go to RD, or to DONE if rcnt==drain_len-1.
  - out_data and out_last are held stable while out_valid&!out_ready.
- out_last=1 only for sel==3 of row drain_len-1.
- DONE: done=1 for one cycle, then IDLE. A start arriving in that DONE cycle is ignored; start is accepted from the next cycle.
- Counter widths are ADDR_BITS+1, so load_len=64 and drain_len=64 address indices 0..63 with no wrap. buf_index and c_index use the low ADDR_BITS bits.
- Per-row drain latency with out_ready tied high: 6 cycles (RD, CAP, 4×OUT).

Test Plan:
- Reset, then idle 5 cycles -> busy=0, in_ready=0, out_valid=0, tpu_in_valid=0, done=0.
- start with load_len=4, drain_len=1, offset=128. Feed in_a=0x11..0x14, in_b=0x21..0x24 with in_valid always high. Model TPU busy high for 10 cycles after launch, and c_data row0 = 0xAAAA_BBBB_CCCC_DDDD_... -> buf_index 0..3 written with matching data. One tpu_in_valid pulse with tpu_input_offset=128. Output words MSB-first, out_last on the 4th. done pulses once.
- Same job with in_valid toggling every other cycle and out_ready low for 3 cycles mid-row -> writes only on handshakes. out_data held stable while stalled. Word order unchanged.
- load_len=0, drain_len=2 -> no buf_wr_en, immediate launch, 8 output words, rows 0 and 1, out_last only on the 8th.
- start pulsed repeatedly during WAIT_LO -> ignored: one launch only, sampled lengths unchanged.
- Assert reset during OUT of row 1 of 3 -> next cycle state IDLE, out_valid=0, busy=0. A new start runs a full job correctly.
